apb_timer_slv: RTL and testbench
================================

# apb_timer_slv

Down-counting timer peripheral on the APB side of the AHB-to-APB bridge; it is one of the slaves driven by a `psel_x` output and returns `prdata_x`/`pready_x`/`pslverr_x` to the bridge read-data, ready and error muxes. It has four memory-mapped word registers, wait states programmable at build time, error responses on illegal accesses, and a level interrupt on underflow.

## Interface
- `DATA_WIDTH`, default 32: APB data width. Must equal `` `APB_DATA_WIDTH ``.
- `ADDR_WIDTH`, default 32: APB address width. Must equal `` `PADDR_WIDTH ``.
- `WAIT_STATES`, default 1: access-phase cycles with `pready`=0 before completion. Legal range 0..7.

Ports:
- `hclk` input 1: the single clock (bridge/APB clock).
- `hreset` input 1: asynchronous, active-high reset.
- `psel` input 1: slave select from the bridge.
- `penable` input 1: APB access phase.
- `paddr` input `ADDR_WIDTH`: only bits [4:0] are decoded.
- `pwrite` input 1: 1 = write.
- `pwdata` input `DATA_WIDTH`: write data.
- `prdata` output `DATA_WIDTH`: read data. Valid only in the completion cycle; 0 otherwise.
- `pready` output 1: transfer completion.
- `pslverr` output 1: error. Valid only when `pready`=1.
- `irq` output 1: level interrupt, registered.

## Operation
Register map (word offsets):
- 0x00 CTRL, RW: bit0 EN, bit1 RELOAD, bit2 IRQEN. Remaining bits read 0.
- 0x04 LOAD, RW, full width.
- 0x08 VALUE, RO: current count.
- 0x0C STATUS: bit0 PEND. Write-1-to-clear.

Access FSM, states IDLE, SETUP, WAIT, ACCESS:
- IDLE goes to SETUP on `psel`&!`penable`.
- SETUP goes to WAIT when `WAIT_STATES`>0, otherwise to ACCESS.
- WAIT counts `WAIT_STATES` cycles and then goes to ACCESS.
- ACCESS drives `pready`=1 for one cycle. It then returns to SETUP if `psel`&!`penable` is present (back-to-back transfer), otherwise to IDLE.
- A `psel` drop mid-transfer returns the FSM to IDLE without side effects.

Error conditions, all of which give `pslverr`=1:
- `paddr[1:0]`≠0.
- Offset above 0x0C (0x10 when the prescaler is built).
- Write to VALUE.

An errored write changes no state. An errored read returns `prdata`=0.

Register commit: writes take effect on the `hclk` edge that ends the ACCESS cycle.
- Writing LOAD also copies the value into VALUE.
- Writing CTRL with EN 0→1 does not reload VALUE.

Counter behaviour while EN=1 and on a tick:
- If VALUE≠0, VALUE decrements by 1.
- If VALUE=0, PEND is set. Then, if RELOAD=1, VALUE←LOAD; otherwise EN←0 and VALUE stays 0.
- Arithmetic is unsigned modulo 2^DATA_WIDTH. LOAD=0 with RELOAD gives PEND every tick.

Priorities when events coincide in one cycle:
- A PEND set from underflow beats a STATUS W1C clear.
- A LOAD write beats decrement and reload.
- A CTRL write beats hardware clearing EN.

`irq` is registered from PEND & IRQEN.

## Timing
- Reset values: all registers 0, FSM IDLE, `prdata`=0, `pready`=0, `pslverr`=0, `irq`=0.
- An asserted `hreset` aborts any transfer and clears all state immediately.
- Transfer latency: `pready` rises in SETUP edge + 1 + `WAIT_STATES` cycles. With `WAIT_STATES`=0 this is the first access cycle (zero-wait APB).
- `pready` is high for exactly one cycle per transfer.
- `irq` follows PEND/IRQEN with one cycle of latency.
- A read of VALUE returns the value sampled in the completion cycle.

## Configuration
- `APB_TIMER_PRESCALE_EN` defined:
  - Adds PRESCALE at 0x10, RW, bits[7:0], reset 0.
  - An 8-bit prescale counter produces a tick every PRESCALE+1 cycles while EN=1.
  - The prescale counter clears when EN=0 or when PRESCALE is written.
- Not defined:
  - A tick occurs every cycle.
  - Offset 0x10 is unmapped and returns `pslverr`.

## Structure
- Shared package/defines file holds:
  - Register offsets (`TMR_CTRL_OFS`…`TMR_PRESC_OFS`).
  - CTRL bit indices.
  - FSM state encoding.
  - Existing `` `APB_DATA_WIDTH ``/`` `PADDR_WIDTH ``.
- One natural sub-module: `apb_timer_core`, containing VALUE, the prescaler, PEND and the underflow logic. The top level holds the APB FSM and the register decode.

## Test plan
- `WAIT_STATES`=1, write LOAD=0x10 then read VALUE → `pready` in the 2nd access cycle; VALUE reads 0x10 (EN=0); `pslverr`=0.
- LOAD=3, CTRL=0x5 (EN, IRQEN, no reload) → PEND after 4 ticks, `irq`=1 one cycle later, EN reads 0, VALUE stays 0.
- LOAD=2, CTRL=0x7 → PEND every 3 ticks with VALUE sequence 2,1,0,2; W1C to STATUS clears `irq`. A clear issued in the same cycle as an underflow leaves PEND=1.
- Write VALUE, read 0x14, and read `paddr`=0x06 → `pslverr`=1 each time, `prdata`=0, no register change.
- `hreset` asserted in the WAIT state → `pready`=0 and all registers 0 immediately; the next transfer completes normally.
- With `APB_TIMER_PRESCALE_EN` defined, PRESCALE=3, LOAD=1, EN → VALUE decrements every 4 cycles. Without it, an access to 0x10 → `pslverr`.

Source files
------------

// File: rtl/apb_timer_slv_pkg.sv
// -----------------------------------------------------------------------------
// apb_timer_slv_pkg
// Shared definitions for the APB down-counting timer slave:
//   - bus width defines `APB_DATA_WIDTH / `PADDR_WIDTH (kept if already defined)
//   - register word offsets TMR_CTRL_OFS .. TMR_PRESC_OFS
//   - CTRL bit indices
//   - APB access FSM state encoding
//   - addr_err(): decode of illegal accesses
// Build option: `APB_TIMER_PRESCALE_EN maps PRESCALE at 0x10; otherwise 0x10
// is unmapped and errors like any other hole.
// -----------------------------------------------------------------------------
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif

package apb_timer_slv_pkg;

    localparam logic [4:0] TMR_CTRL_OFS   = 5'h00;
    localparam logic [4:0] TMR_LOAD_OFS   = 5'h04;
    localparam logic [4:0] TMR_VALUE_OFS  = 5'h08;
    localparam logic [4:0] TMR_STATUS_OFS = 5'h0C;
    localparam logic [4:0] TMR_PRESC_OFS  = 5'h10;

`ifdef APB_TIMER_PRESCALE_EN
    localparam logic [4:0] TMR_LAST_OFS = TMR_PRESC_OFS;
`else
    localparam logic [4:0] TMR_LAST_OFS = TMR_STATUS_OFS;
`endif

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_RELOAD_BIT = 1;
    localparam int CTRL_IRQEN_BIT  = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_ACCESS = 2'd3;

    // Misaligned, beyond the last mapped word, or a write to read-only VALUE.
    function automatic logic addr_err(input logic [4:0] ofs, input logic wr);
        return (ofs[1:0] != 2'b00) || (ofs > TMR_LAST_OFS) ||
               (wr && (ofs == TMR_VALUE_OFS));
    endfunction

endpackage

// File: rtl/apb_timer_core.sv
// -----------------------------------------------------------------------------
// apb_timer_core
// Timer datapath: CTRL/LOAD/VALUE/PEND registers, optional prescaler,
// underflow handling and the registered interrupt.
// Ports:
//   hclk, hreset          clock, asynchronous active-high reset
//   ctrl_we/load_we/status_we/presc_we  one-cycle commit strobes from the bus
//   wdata                 bus write data
//   ctrl_en/ctrl_reload/ctrl_irqen, load_val, value, pend, presc  register views
//   irq                   registered PEND & IRQEN
// Build option: `APB_TIMER_PRESCALE_EN adds the 8-bit PRESCALE register and
// prescale counter; otherwise the counter ticks every cycle while enabled.
// -----------------------------------------------------------------------------
module apb_timer_core
    import apb_timer_slv_pkg::*;
#(
    parameter int DATA_WIDTH = `APB_DATA_WIDTH
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  ctrl_we,
    input  logic                  load_we,
    input  logic                  status_we,
    input  logic                  presc_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ctrl_en,
    output logic                  ctrl_reload,
    output logic                  ctrl_irqen,
    output logic [DATA_WIDTH-1:0] load_val,
    output logic [DATA_WIDTH-1:0] value,
    output logic                  pend,
    output logic [7:0]            presc,
    output logic                  irq
);

    logic                  en_reg, reload_reg, irqen_reg, pend_reg, irq_reg;
    logic [DATA_WIDTH-1:0] load_reg, value_reg;
    logic                  tick, underflow;

`ifdef APB_TIMER_PRESCALE_EN
    logic [7:0] presc_reg, pcnt_reg;

    // Tick on the cycle the counter reaches PRESCALE: one tick per PRESCALE+1 cycles.
    assign tick  = en_reg && (pcnt_reg == presc_reg);
    assign presc = presc_reg;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            presc_reg <= 8'd0;
            pcnt_reg  <= 8'd0;
        end else begin
            if (presc_we)
                presc_reg <= wdata[7:0];
            if (!en_reg || presc_we || tick)
                pcnt_reg <= 8'd0;
            else
                pcnt_reg <= pcnt_reg + 8'd1;
        end
    end
`else
    wire unused_presc_we = presc_we;

    assign tick  = en_reg;
    assign presc = 8'd0;
`endif

    assign underflow = tick && (value_reg == '0);

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            en_reg     <= 1'b0;
            reload_reg <= 1'b0;
            irqen_reg  <= 1'b0;
            load_reg   <= '0;
            value_reg  <= '0;
            pend_reg   <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            // A CTRL write wins over the one-shot auto-disable.
            if (ctrl_we) begin
                en_reg     <= wdata[CTRL_EN_BIT];
                reload_reg <= wdata[CTRL_RELOAD_BIT];
                irqen_reg  <= wdata[CTRL_IRQEN_BIT];
            end else if (underflow && !reload_reg) begin
                en_reg <= 1'b0;
            end

            if (load_we)
                load_reg <= wdata;

            // A LOAD write wins over both decrement and reload.
            if (load_we)
                value_reg <= wdata;
            else if (underflow)
                value_reg <= reload_reg ? load_reg : '0;
            else if (tick)
                value_reg <= value_reg - 1'b1;

            // Underflow wins over a simultaneous W1C.
            if (underflow)
                pend_reg <= 1'b1;
            else if (status_we && wdata[0])
                pend_reg <= 1'b0;

            irq_reg <= pend_reg && irqen_reg;
        end
    end

    assign ctrl_en     = en_reg;
    assign ctrl_reload = reload_reg;
    assign ctrl_irqen  = irqen_reg;
    assign load_val    = load_reg;
    assign value       = value_reg;
    assign pend        = pend_reg;
    assign irq         = irq_reg;

endmodule

// File: rtl/apb_timer_slv.sv
// -----------------------------------------------------------------------------
// apb_timer_slv
// APB down-counting timer slave: access FSM with build-time wait states,
// register decode, error response, and the apb_timer_core datapath.
// Parameters: DATA_WIDTH, ADDR_WIDTH, WAIT_STATES (0..7).
// Ports:
//   hclk, hreset                  clock, asynchronous active-high reset
//   psel, penable, paddr, pwrite, pwdata   APB request (paddr[4:0] decoded)
//   prdata, pready, pslverr       APB response, valid in the completion cycle
//   irq                           registered level interrupt
// Build option: `APB_TIMER_PRESCALE_EN maps PRESCALE at offset 0x10.
// -----------------------------------------------------------------------------
module apb_timer_slv
    import apb_timer_slv_pkg::*;
#(
    parameter int DATA_WIDTH  = `APB_DATA_WIDTH,
    parameter int ADDR_WIDTH  = `PADDR_WIDTH,
    parameter int WAIT_STATES = 1
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  irq
);

    logic [1:0] state_reg, state_next, phase;
    logic [2:0] wait_cnt_reg, wait_cnt_next;
    logic [4:0] ofs;
    logic       bad, commit;
    logic       ctrl_we, load_we, status_we, presc_we;
    logic       ctrl_en, ctrl_reload, ctrl_irqen, pend;
    logic [DATA_WIDTH-1:0] load_val, value, rd_word;
    logic [7:0] presc_val;

    wire unused_paddr_hi = &{1'b0, paddr[ADDR_WIDTH-1:5]};

    assign ofs = paddr[4:0];

    // SETUP is the APB setup cycle itself, so it is recognised from the bus
    // while the register still says IDLE. ACCESS always registers back to
    // IDLE; a back-to-back setup in the following cycle is then seen as
    // SETUP directly, which gives the ACCESS->SETUP path without a lost cycle.
    always_comb begin
        phase = state_reg;
        if (state_reg == ST_IDLE && psel && !penable)
            phase = ST_SETUP;
    end

    always_comb begin
        state_next    = ST_IDLE;
        wait_cnt_next = wait_cnt_reg;
        case (phase)
            ST_SETUP: begin
                wait_cnt_next = 3'd0;
                state_next    = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
            end
            ST_WAIT: begin
                if (!psel)
                    state_next = ST_IDLE;
                else if ((wait_cnt_reg + 3'd1) == 3'(WAIT_STATES))
                    state_next = ST_ACCESS;
                else begin
                    state_next    = ST_WAIT;
                    wait_cnt_next = wait_cnt_reg + 3'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 3'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // A dropped psel in ACCESS completes nothing and commits nothing.
    assign pready  = (state_reg == ST_ACCESS) && psel && penable;
    assign bad     = addr_err(ofs, pwrite);
    assign pslverr = pready && bad;
    assign commit  = pready && pwrite && !bad;

    assign ctrl_we   = commit && (ofs == TMR_CTRL_OFS);
    assign load_we   = commit && (ofs == TMR_LOAD_OFS);
    assign status_we = commit && (ofs == TMR_STATUS_OFS);
    assign presc_we  = commit && (ofs == TMR_PRESC_OFS);

    always_comb begin
        rd_word = '0;
        case (ofs)
            TMR_CTRL_OFS: begin
                rd_word[CTRL_EN_BIT]     = ctrl_en;
                rd_word[CTRL_RELOAD_BIT] = ctrl_reload;
                rd_word[CTRL_IRQEN_BIT]  = ctrl_irqen;
            end
            TMR_LOAD_OFS:   rd_word = load_val;
            TMR_VALUE_OFS:  rd_word = value;
            TMR_STATUS_OFS: rd_word[0] = pend;
`ifdef APB_TIMER_PRESCALE_EN
            TMR_PRESC_OFS:  rd_word[7:0] = presc_val;
`endif
            default:        rd_word = '0;
        endcase
    end

`ifndef APB_TIMER_PRESCALE_EN
    wire unused_presc_val = |presc_val;
`endif

    assign prdata = (pready && !pwrite && !bad) ? rd_word : '0;

    apb_timer_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_core (
        .hclk       (hclk),
        .hreset     (hreset),
        .ctrl_we    (ctrl_we),
        .load_we    (load_we),
        .status_we  (status_we),
        .presc_we   (presc_we),
        .wdata      (pwdata),
        .ctrl_en    (ctrl_en),
        .ctrl_reload(ctrl_reload),
        .ctrl_irqen (ctrl_irqen),
        .load_val   (load_val),
        .value      (value),
        .pend       (pend),
        .presc      (presc_val),
        .irq        (irq)
    );

endmodule

// File: tb/tb_apb_timer_slv.sv
// -----------------------------------------------------------------------------
// tb_apb_timer_slv
// Directed test of apb_timer_slv (WAIT_STATES=1). A register-level model of
// the timer is advanced every clock from the bus it observes; a compare
// process checks pready/pslverr/prdata/irq against it on every negedge.
// Directed reads are also checked against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_apb_timer_slv;

    localparam int WS = 1;

    logic        hclk    = 1'b0;
    logic        hreset  = 1'b1;
    logic        psel    = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic [31:0] paddr   = 32'd0;
    logic [31:0] pwdata  = 32'd0;
    logic [31:0] prdata;
    logic        pready, pslverr, irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 hclk = ~hclk;

    apb_timer_slv #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .WAIT_STATES(WS)
    ) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .psel   (psel),
        .penable(penable),
        .paddr  (paddr),
        .pwrite (pwrite),
        .pwdata (pwdata),
        .prdata (prdata),
        .pready (pready),
        .pslverr(pslverr),
        .irq    (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_en = 0, m_reload = 0, m_irqen = 0, m_pend = 0, m_irq = 0, m_active = 0;
    logic [31:0] m_load = 0, m_val = 0;
    logic [7:0]  m_presc = 0, m_pcnt = 0;
    int          m_acc = 0;

    function automatic logic bad_addr(input logic [31:0] a, input logic wr);
        int o;
        int last;
        o = int'(a[4:0]);
`ifdef APB_TIMER_PRESCALE_EN
        last = 16;
`else
        last = 12;
`endif
        return ((o % 4) != 0) || (o > last) || (wr && o == 8);
    endfunction

    function automatic logic [31:0] reg_read(input logic [31:0] a);
        case (int'(a[4:0]))
            0:  return {29'd0, m_irqen, m_reload, m_en};
            4:  return m_load;
            8:  return m_val;
            12: return {31'd0, m_pend};
`ifdef APB_TIMER_PRESCALE_EN
            16: return {24'd0, m_presc};
`endif
            default: return 32'd0;
        endcase
    endfunction

    logic        u_done, u_wr, u_tick, u_under;
    logic        n_en, n_reload, n_irqen, n_pend;
    logic [31:0] n_load, n_val;
    logic [7:0]  n_presc, n_pcnt;

    initial forever begin
        @(posedge hclk);
        if (hreset) begin
            m_en = 0; m_reload = 0; m_irqen = 0; m_pend = 0; m_irq = 0;
            m_load = 0; m_val = 0; m_presc = 0; m_pcnt = 0;
            m_active = 0; m_acc = 0;
        end else begin
            u_done = m_active && psel && penable && (m_acc == WS);
            u_wr   = u_done && pwrite && !bad_addr(paddr, 1'b1);
`ifdef APB_TIMER_PRESCALE_EN
            u_tick = m_en && (m_pcnt == m_presc);
`else
            u_tick = m_en;
`endif
            u_under = u_tick && (m_val == 0);
            n_en = m_en; n_reload = m_reload; n_irqen = m_irqen; n_pend = m_pend;
            n_load = m_load; n_val = m_val; n_presc = m_presc;
            n_pcnt = (!m_en || u_tick) ? 8'd0 : m_pcnt + 8'd1;
            // timer on its own
            if (u_tick) begin
                if (m_val != 0) n_val = m_val - 1;
                else begin
                    n_pend = 1;
                    if (m_reload) n_val = m_load;
                    else n_en = 0;
                end
            end
            // bus writes override the timer, except that PEND set survives a clear
            if (u_wr) begin
                case (int'(paddr[4:0]))
                    0: begin n_en = pwdata[0]; n_reload = pwdata[1]; n_irqen = pwdata[2]; end
                    4: begin n_load = pwdata; n_val = pwdata; end
                    12: if (pwdata[0] && !u_under) n_pend = 0;
`ifdef APB_TIMER_PRESCALE_EN
                    16: begin n_presc = pwdata[7:0]; n_pcnt = 0; end
`endif
                    default: ;
                endcase
            end
            m_irq = m_pend && m_irqen;
            m_en = n_en; m_reload = n_reload; m_irqen = n_irqen; m_pend = n_pend;
            m_load = n_load; m_val = n_val; m_presc = n_presc; m_pcnt = n_pcnt;
            // transfer tracking: count access cycles since the setup cycle
            if (!psel) m_active = 0;
            else if (!penable) begin m_active = 1; m_acc = 0; end
            else if (m_active) begin
                if (u_done) m_active = 0;
                else m_acc = m_acc + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic        c_rdy, c_bad;
    logic [31:0] c_rd;

    initial forever begin
        @(negedge hclk);
        if (hreset) begin
            check("rst_pready", pready, 0);
            check("rst_pslverr", pslverr, 0);
            check("rst_prdata", prdata, 0);
            check("rst_irq", irq, 0);
        end else begin
            c_rdy = m_active && psel && penable && (m_acc == WS);
            c_bad = bad_addr(paddr, pwrite);
            c_rd  = (c_rdy && !pwrite && !c_bad) ? reg_read(paddr) : 32'd0;
            check("pready", pready, c_rdy);
            if (c_rdy) check("pslverr", pslverr, c_bad);
            check("prdata", prdata, c_rd);
            check("irq", irq, m_irq);
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1; returns at posedge+1 of the cycle after completion.
    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int ncyc);
        logic got;
        got = 0; rd = 32'd0; err = 1'b0; ncyc = 0;
        psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge hclk); #1;
        penable = 1;
        while (!got && ncyc < 20) begin
            @(negedge hclk);
            ncyc++;
            if (pready) begin
                got = 1; rd = prdata; err = pslverr;
            end
            @(posedge hclk); #1;
        end
        psel = 0; penable = 0;
        if (!got) check("timeout", 0, 1);
        $display("xfer %s addr=0x%02h wd=0x%0h rd=0x%0h err=%0b cycles=%0d",
                 wr ? "WR" : "RD", addr[7:0], wd, rd, err, ncyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge hclk); #1; end
    endtask

    logic [31:0] rd;
    logic        er;
    int          nc;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        hreset = 1;
        repeat (3) @(posedge hclk);
        #1 hreset = 0;
        check("irq_after_reset", irq, 0);
        apb(0, 32'h00, 0, rd, er, nc); check("ctrl_reset", rd, 0);

        // LOAD then VALUE readback, one wait state
        apb(1, 32'h04, 32'h10, rd, er, nc); check("load_err", er, 0); check("load_lat", nc, 2);
        apb(0, 32'h08, 0, rd, er, nc); check("value_rd", rd, 32'h10); check("value_err", er, 0);
        check("value_lat", nc, 2);

        // one-shot: LOAD=3, EN|IRQEN
        apb(1, 32'h04, 3, rd, er, nc);
        apb(1, 32'h00, 5, rd, er, nc);
        idle(8);
        check("oneshot_irq", irq, 1);
        apb(0, 32'h00, 0, rd, er, nc); check("oneshot_ctrl", rd, 4);
        apb(0, 32'h08, 0, rd, er, nc); check("oneshot_value", rd, 0);
        apb(0, 32'h0C, 0, rd, er, nc); check("oneshot_pend", rd, 1);
        apb(1, 32'h0C, 1, rd, er, nc);
        idle(2);
        check("w1c_irq", irq, 0);
        apb(0, 32'h0C, 0, rd, er, nc); check("w1c_pend", rd, 0);

        // periodic: LOAD=2, EN|RELOAD|IRQEN -> VALUE 2,1,0,2,...
        apb(1, 32'h04, 2, rd, er, nc);
        apb(1, 32'h00, 7, rd, er, nc);
        apb(0, 32'h08, 0, rd, er, nc); check("reload_v0", rd, 0);
        idle(1);
        apb(0, 32'h08, 0, rd, er, nc); check("reload_v1", rd, 2);
        idle(1);
        apb(0, 32'h08, 0, rd, er, nc); check("reload_v2", rd, 1);
        idle(1);
        apb(1, 32'h0C, 1, rd, er, nc);          // completes on an underflow cycle
        apb(0, 32'h0C, 0, rd, er, nc); check("clear_vs_underflow", rd, 1);
        check("periodic_irq", irq, 1);
        apb(1, 32'h00, 0, rd, er, nc);
        apb(1, 32'h0C, 1, rd, er, nc);
        idle(2);
        check("stop_irq", irq, 0);

        // error responses
        apb(1, 32'h04, 32'h55, rd, er, nc);
        apb(1, 32'h08, 32'h99, rd, er, nc); check("wr_value_err", er, 1);
        apb(0, 32'h08, 0, rd, er, nc); check("value_kept", rd, 32'h55); check("value_kept_err", er, 0);
        apb(0, 32'h14, 0, rd, er, nc); check("rd14_err", er, 1); check("rd14_data", rd, 0);
        apb(0, 32'h06, 0, rd, er, nc); check("rd06_err", er, 1); check("rd06_data", rd, 0);
        apb(0, 32'h04, 0, rd, er, nc); check("load_kept", rd, 32'h55);
`ifdef APB_TIMER_PRESCALE_EN
        apb(1, 32'h10, 3, rd, er, nc); check("presc_wr_err", er, 0);
        apb(0, 32'h10, 0, rd, er, nc); check("presc_rd", rd, 3);
        apb(1, 32'h04, 1, rd, er, nc);
        apb(1, 32'h00, 1, rd, er, nc);
        idle(3);
        apb(0, 32'h08, 0, rd, er, nc);
        idle(4);
        apb(0, 32'h08, 0, rd, er, nc);
        idle(6);
        apb(0, 32'h08, 0, rd, er, nc); check("presc_final", rd, 0);
        apb(0, 32'h0C, 0, rd, er, nc); check("presc_pend", rd, 1);
        apb(1, 32'h0C, 1, rd, er, nc);
`else
        apb(0, 32'h10, 0, rd, er, nc); check("rd10_err", er, 1); check("rd10_data", rd, 0);
        apb(1, 32'h10, 5, rd, er, nc); check("wr10_err", er, 1);
`endif

        // reset while in the wait state
        apb(1, 32'h04, 32'h77, rd, er, nc);
        apb(1, 32'h00, 32'h4, rd, er, nc);
        psel = 1; penable = 0; pwrite = 0; paddr = 32'h08;
        @(posedge hclk); #1;
        penable = 1;
        hreset = 1;
        #1 check("rst_wait_pready", pready, 0);
        check("rst_wait_prdata", prdata, 0);
        @(posedge hclk); #1;
        psel = 0; penable = 0; hreset = 0;
        apb(0, 32'h08, 0, rd, er, nc); check("post_rst_value", rd, 0); check("post_rst_lat", nc, 2);
        apb(0, 32'h04, 0, rd, er, nc); check("post_rst_load", rd, 0);
        apb(0, 32'h00, 0, rd, er, nc); check("post_rst_ctrl", rd, 0);
        apb(1, 32'h04, 32'h21, rd, er, nc); check("post_rst_wr_err", er, 0);
        apb(0, 32'h08, 0, rd, er, nc); check("post_rst_rd", rd, 32'h21);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
